// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: issues one SRAM-like bus fetch per PC, holds the
// returned word for decode, stalls the PC register and discards stale responses.
module ifetch_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    input  logic             stall_d,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic [WIDTH-1:0] inst_out,
    output logic             inst_valid,
    output logic             stall_f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             discard_q, discard_d;
    logic             inst_valid_q, inst_valid_d;
    logic [WIDTH-1:0] inst_out_q, inst_out_d;
    logic [WIDTH-1:0] addr_q, addr_d;

    // State register and held instruction/address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= {WIDTH{1'b0}};
            addr_q       <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            addr_q       <= addr_d;
        end
    end

    // Next-state and bus request generation
    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        addr_d       = addr_q;
        inst_req     = 1'b0;
        inst_addr    = addr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                inst_req  = 1'b1;
                inst_addr = pc;
                if (inst_addr_ok) begin
                    // The accepted address is the old pc if a redirect coincides.
                    state_d   = WAIT;
                    addr_d    = pc;
                    discard_d = flush;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        inst_out_d   = inst_rdata;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (flush || !stall_d) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d      = IDLE;
                discard_d    = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    assign stall_f    = !(((state_q == HOLD) && !stall_d) || flush);
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios with a scoreboard of
// instructions expected to reach decode.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        flush, stall_d;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        stall_f;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic        prev_valid = 1'b0;

    ifetch_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst_n), .pc(pc), .flush(flush), .stall_d(stall_d),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_out(inst_out),
        .inst_valid(inst_valid), .stall_f(stall_f)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rising inst_valid must deliver the oldest expected word
    always @(negedge clk) begin
        #2;
        if (rst_n && inst_valid && !prev_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: inst_valid rose with inst_out=%h, nothing expected", inst_out);
            end else begin
                logic [31:0] exp;
                exp = sb_q.pop_front();
                if (inst_out !== exp) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h", inst_out, exp);
                end
            end
        end
        prev_valid = inst_valid;
    end

    // Advance to the next REQ cycle (returns at negedge+1), bounded
    task automatic wait_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (inst_req === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_req_timeout: inst_req=%b required 1", inst_req);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = 32'hbfc00000; flush = 1'b0; stall_d = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        @(negedge clk); #1;
        checks++;
        if ({inst_req, inst_addr, stall_f, inst_valid, inst_out} !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h stall_f=%b valid=%b out=%h required 0 0 1 0 0",
                     inst_req, inst_addr, stall_f, inst_valid, inst_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        wait_req();
        checks++;
        if ({inst_addr, stall_f} !== {32'hbfc00000, 1'b1}) begin
            errors++;
            $display("FAIL basic_req: addr=%h stall_f=%b required bfc00000 1", inst_addr, stall_f);
        end
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d0001;
        sb_q.push_back(32'h3c1d0001);
        #1;
        checks++;
        if ({inst_req, inst_valid, inst_addr} !== {1'b0, 1'b0, 32'hbfc00000}) begin
            errors++;
            $display("FAIL basic_wait: req=%b valid=%b addr=%h required 0 0 bfc00000", inst_req, inst_valid, inst_addr);
        end
        @(negedge clk);
        inst_data_ok = 1'b0; #1;
        checks++;
        if ({inst_valid, inst_out, stall_f, inst_req} !== {1'b1, 32'h3c1d0001, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: valid=%b out=%h stall_f=%b req=%b required 1 3c1d0001 0 0",
                     inst_valid, inst_out, stall_f, inst_req);
        end
        @(negedge clk);
        pc = 32'hbfc00004; #1;
        checks++;
        if ({stall_f, inst_req, inst_addr, inst_valid} !== {1'b1, 1'b1, 32'hbfc00004, 1'b0}) begin
            errors++;
            $display("FAIL basic_next: stall_f=%b req=%b addr=%h valid=%b required 1 1 bfc00004 0",
                     stall_f, inst_req, inst_addr, inst_valid);
        end
    endtask

    task automatic test_stall_hold();
        // Still in REQ and not accepted: the address follows pc
        pc = 32'hbfc00000; #1;
        checks++;
        if (inst_addr !== 32'hbfc00000) begin
            errors++;
            $display("FAIL stall_addr_follow: addr=%h required bfc00000", inst_addr);
        end
        inst_addr_ok = 1'b1; stall_d = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24080004;
        sb_q.push_back(32'h24080004);
        @(negedge clk);
        inst_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if ({inst_valid, inst_out, stall_f, inst_req} !== {1'b1, 32'h24080004, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b out=%h stall_f=%b req=%b required 1 24080004 1 0",
                         i, inst_valid, inst_out, stall_f, inst_req);
            end
        end
        @(negedge clk);
        stall_d = 1'b0; #1;
        checks++;
        if ({stall_f, inst_valid} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: stall_f=%b valid=%b required 0 1", stall_f, inst_valid);
        end
        @(negedge clk);
        pc = 32'hbfc00004; #1;
        checks++;
        if ({inst_req, inst_addr, stall_f} !== {1'b1, 32'hbfc00004, 1'b1}) begin
            errors++;
            $display("FAIL stall_next_req: req=%b addr=%h stall_f=%b required 1 bfc00004 1", inst_req, inst_addr, stall_f);
        end
    endtask

    task automatic test_flush_wait();
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; flush = 1'b1; #1;
        checks++;
        if ({stall_f, inst_req} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flushw_stall: stall_f=%b req=%b required 0 0", stall_f, inst_req);
        end
        @(negedge clk);
        flush = 1'b0; pc = 32'hbfc00380; #1;
        checks++;
        if ({inst_req, inst_addr} !== {1'b0, 32'hbfc00004}) begin
            errors++;
            $display("FAIL flushw_hold_addr: req=%b addr=%h required 0 bfc00004", inst_req, inst_addr);
        end
        @(negedge clk);
        inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
        @(negedge clk);
        inst_data_ok = 1'b0; #1;
        checks++;
        if ({inst_req, inst_addr, inst_valid} !== {1'b1, 32'hbfc00380, 1'b0}) begin
            errors++;
            $display("FAIL flushw_refetch: req=%b addr=%h valid=%b required 1 bfc00380 0", inst_req, inst_addr, inst_valid);
        end
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c080380;
        sb_q.push_back(32'h3c080380);
        @(negedge clk);
        inst_data_ok = 1'b0;
        @(negedge clk);
        pc = 32'hbfc00384; #1;
    endtask

    task automatic test_flush_req();
        checks++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hbfc00384}) begin
            errors++;
            $display("FAIL flushr_req: req=%b addr=%h required 1 bfc00384", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1; flush = 1'b1; #1;
        checks++;
        if (stall_f !== 1'b0) begin
            errors++;
            $display("FAIL flushr_stall: stall_f=%b required 0", stall_f);
        end
        @(negedge clk);
        inst_addr_ok = 1'b0; flush = 1'b0; pc = 32'hbfc00100;
        @(negedge clk);
        inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
        @(negedge clk);
        inst_data_ok = 1'b0; #1;
        checks++;
        if ({inst_req, inst_addr, inst_valid} !== {1'b1, 32'hbfc00100, 1'b0}) begin
            errors++;
            $display("FAIL flushr_refetch: req=%b addr=%h valid=%b required 1 bfc00100 0", inst_req, inst_addr, inst_valid);
        end
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h33333333;
        sb_q.push_back(32'h33333333);
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushr_early_valid: valid=%b required 0", inst_valid);
        end
    endtask

    task automatic test_flush_hold();
        @(negedge clk);
        inst_data_ok = 1'b0; stall_d = 1'b1; flush = 1'b1; #1;
        checks++;
        if ({inst_valid, inst_out, stall_f} !== {1'b1, 32'h33333333, 1'b0}) begin
            errors++;
            $display("FAIL flushh_cycle: valid=%b out=%h stall_f=%b required 1 33333333 0", inst_valid, inst_out, stall_f);
        end
        @(negedge clk);
        flush = 1'b0; stall_d = 1'b0; pc = 32'hbfc00200; #1;
        checks++;
        if ({inst_valid, inst_req, inst_addr, inst_out} !== {1'b0, 1'b1, 32'hbfc00200, 32'h33333333}) begin
            errors++;
            $display("FAIL flushh_after: valid=%b req=%b addr=%h out=%h required 0 1 bfc00200 33333333",
                     inst_valid, inst_req, inst_addr, inst_out);
        end
    endtask

    task automatic test_reset_wait();
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; #1;
        rst_n = 1'b0; #1;
        checks++;
        if ({inst_req, inst_addr, stall_f, inst_valid, inst_out} !== {1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstw_outputs: req=%b addr=%h stall_f=%b valid=%b out=%h required 0 0 1 0 0",
                     inst_req, inst_addr, stall_f, inst_valid, inst_out);
        end
        @(negedge clk);
        rst_n = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
        @(negedge clk);
        inst_data_ok = 1'b0; #1;
        checks++;
        if ({inst_req, inst_addr, inst_valid} !== {1'b1, 32'hbfc00200, 1'b0}) begin
            errors++;
            $display("FAIL rstw_req: req=%b addr=%h valid=%b required 1 bfc00200 0", inst_req, inst_addr, inst_valid);
        end
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h44444444;
        sb_q.push_back(32'h44444444);
        @(negedge clk);
        inst_data_ok = 1'b0; #1;
        checks++;
        if ({inst_valid, inst_out} !== {1'b1, 32'h44444444}) begin
            errors++;
            $display("FAIL rstw_fetch: valid=%b out=%h required 1 44444444", inst_valid, inst_out);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_flush_wait();
        test_flush_req();
        test_flush_hold();
        test_reset_wait();
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected words never delivered, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
